// File: rtl/sys_defs.sv
// Shared constants and the OARAM beat bundle for the post-processing unit.
package sys_defs;

    // Lanes per OARAM beat and width of the zero-run index.
    localparam int num_of_outputs_PPU = 4;
    localparam int bits_of_indices    = 4;
    localparam int PPU_DATA_W         = 16;

    // One OARAM beat: per-lane valid, compressed data and zero-run indices.
    typedef struct packed {
        logic [num_of_outputs_PPU-1:0]                      valid;
        logic [num_of_outputs_PPU-1:0][PPU_DATA_W-1:0]      output_data;
        logic [num_of_outputs_PPU-1:0][bits_of_indices-1:0] output_indices;
    } PPU_OARAM;

    // Sweep controller states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } ppu_state_e;

endpackage

// File: rtl/ppu_rle_packer.sv
// Zero-run encoder plus lane packer and output holding register.
// Accepts one activation per cycle whenever the holding register can take a
// new group, so a completing group never has to wait on a pending beat.
module ppu_rle_packer
    import sys_defs::*;
#(
    parameter int CNT_OUT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [PPU_DATA_W-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_in_ready,
    output logic                  o_drained,
    output logic [CNT_OUT_W-1:0]  o_count,
    output PPU_OARAM              o_hold
);

    localparam int N  = num_of_outputs_PPU;
    localparam int DW = PPU_DATA_W;
    localparam int IW = bits_of_indices;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0]        RUN_MAX   = '1;
    localparam logic [IW-1:0]        RUN_ONE   = IW'(1);
    localparam logic [CW-1:0]        LAST_LANE = CW'(N - 1);
    localparam logic [CW-1:0]        FILL_ONE  = CW'(1);
    localparam logic [CNT_OUT_W-1:0] CNT_ONE   = CNT_OUT_W'(1);

    logic [IW-1:0]        r_run;
    logic [CW-1:0]        r_fill;
    logic [CNT_OUT_W-1:0] r_count;
    PPU_OARAM             r_hold;
    PPU_OARAM             w_hold_next;

    // Lanes 0..N-2 are staged here; the last lane only ever completes a group.
    logic [DW-1:0] r_lane_data [N-1];
    logic [IW-1:0] r_lane_idx  [N-1];

    logic [N-1:0]         w_nx_valid;
    logic [N-1:0][DW-1:0] w_nx_data;
    logic [N-1:0][IW-1:0] w_nx_idx;

    logic w_hold_busy;
    logic w_in_ready;
    logic w_take;
    logic w_emit;
    logic w_group_done;
    logic w_flush_load;
    logic w_load;

    assign w_hold_busy  = |r_hold.valid;
    assign w_in_ready   = !w_hold_busy || i_ready;
    assign w_take       = i_valid && w_in_ready;
    assign w_emit       = w_take && ((i_data != '0) || (r_run == RUN_MAX));
    assign w_group_done = w_emit && (r_fill == LAST_LANE);
    assign w_flush_load = i_flush && !i_valid && (r_fill != '0) && w_in_ready;
    assign w_load       = w_group_done || w_flush_load;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            if (gi == N - 1) begin : g_last
                assign w_nx_valid[gi] = w_group_done;
                assign w_nx_data[gi]  = w_group_done ? i_data : '0;
                assign w_nx_idx[gi]   = w_group_done ? r_run  : '0;
            end else begin : g_staged
                // Stage an emitted pair in this lane; clear once the group leaves.
                always_ff @(posedge clk) begin
                    if (rst || i_clear || w_load) begin
                        r_lane_data[gi] <= '0;
                        r_lane_idx[gi]  <= '0;
                    end else if (w_emit && (r_fill == CW'(gi))) begin
                        r_lane_data[gi] <= i_data;
                        r_lane_idx[gi]  <= r_run;
                    end
                end
                assign w_nx_valid[gi] = w_group_done || (CW'(gi) < r_fill);
                assign w_nx_data[gi]  = r_lane_data[gi];
                assign w_nx_idx[gi]   = r_lane_idx[gi];
            end
        end
    endgenerate

    assign w_hold_next = '{valid: w_nx_valid, output_data: w_nx_data, output_indices: w_nx_idx};

    // Run counter, lane fill pointer, pair count and holding register.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_run   <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_take) begin
                r_run <= w_emit ? '0 : (r_run + RUN_ONE);
            end
            if (w_emit) begin
                r_count <= r_count + CNT_ONE;
                r_fill  <= w_group_done ? '0 : (r_fill + FILL_ONE);
            end
            if (w_flush_load) begin
                r_fill <= '0;
            end
            if (w_load) begin
                r_hold <= w_hold_next;
            end else if (w_hold_busy && i_ready) begin
                r_hold <= '0;
            end
        end
    end

    assign o_in_ready = w_in_ready;
    // Nothing staged, nothing entering a lane, and the beat (if any) leaving now.
    assign o_drained  = (r_fill == '0) && !w_emit && (!w_hold_busy || i_ready);
    assign o_count    = r_count;
    assign o_hold     = r_hold;

endmodule

// File: rtl/ppu_relu_compress.sv
// Post-processing sweep: reads the accumulator bank in order, applies shift,
// ReLU and saturation, and hands each activation to the RLE packer.
// The oaram_* widths follow sys_defs; DATA_W/IDX_W/N_OUT must agree with it.
module ppu_relu_compress
    import sys_defs::*;
#(
    parameter int ACC_W  = 24,
    parameter int DATA_W = PPU_DATA_W,
    parameter int IDX_W  = bits_of_indices,
    parameter int N_OUT  = num_of_outputs_PPU,
    parameter int ADDR_W = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_W:0]                 num_outputs,
    input  logic [4:0]                      shift,
    output logic                            acc_rd_en,
    output logic [ADDR_W-1:0]               acc_rd_addr,
    input  logic signed [ACC_W-1:0]         acc_rd_data,
    output logic [N_OUT-1:0]                oaram_valid,
    output logic [N_OUT-1:0][DATA_W-1:0]    oaram_data,
    output logic [N_OUT-1:0][IDX_W-1:0]     oaram_indices,
    input  logic                            oaram_ready,
    output logic                            busy,
    output logic                            ppu_finish_en,
    output logic [ADDR_W:0]                 num_compressed
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic [ADDR_W:0]         ONE     = (ADDR_W + 1)'(1);

    ppu_state_e        r_state;
    logic [ADDR_W:0]   r_num;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_left;
    logic [4:0]        r_shift;
    logic              r_rd_pend;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_busy;
    logic              r_finish;
    logic [ADDR_W:0]   r_num_comp;

    logic              w_in_valid;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_relu;
    logic              w_in_ready;
    logic              w_proc;
    logic              w_last;
    logic              w_drained;
    logic              w_clear;
    logic              w_flush;
    logic [ADDR_W:0]   w_count;
    PPU_OARAM          w_hold;

    // Arithmetic shift, clamp negatives to zero, saturate to the positive max.
    function automatic logic [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] a,
                                                   input logic [4:0] sh);
        logic signed [ACC_W-1:0] s;
        s = a >>> sh;
        if (s[ACC_W-1]) return '0;
        if (s > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        return s[DATA_W-1:0];
    endfunction

    assign w_relu     = relu_sat(acc_rd_data, r_shift);
    assign w_in_valid = r_skid_valid || r_rd_pend;
    assign w_in_data  = r_skid_valid ? r_skid_data : w_relu;
    assign w_proc     = w_in_valid && w_in_ready;
    assign w_last     = w_proc && (r_left == ONE);
    assign w_clear    = (r_state == S_IDLE) && start;
    assign w_flush    = (r_state == S_FLUSH);

    // Only read when the packer can take the result, so at most one read is
    // ever in flight against a blocked holding register.
    assign acc_rd_en   = (r_state == S_READ) && (r_issued != r_num) && w_in_ready;
    assign acc_rd_addr = r_issued[ADDR_W-1:0];

    ppu_rle_packer #(
        .CNT_OUT_W (ADDR_W + 1)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_flush    (w_flush),
        .i_valid    (w_in_valid),
        .i_data     (w_in_data),
        .i_ready    (oaram_ready),
        .o_in_ready (w_in_ready),
        .o_drained  (w_drained),
        .o_count    (w_count),
        .o_hold     (w_hold)
    );

    // Track the in-flight read and park its result if the packer is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_rd_pend <= acc_rd_en;
            if (r_rd_pend && !w_in_ready) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_relu;
            end else if (w_in_ready) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // Sweep controller with registered busy / finish / pair-count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_issued   <= '0;
            r_left     <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_num_comp <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num    <= num_outputs;
                        r_left   <= num_outputs;
                        r_shift  <= shift;
                        r_issued <= '0;
                        if (num_outputs == '0) begin
                            r_state    <= S_DONE;
                            r_finish   <= 1'b1;
                            r_num_comp <= '0;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (acc_rd_en) begin
                        r_issued <= r_issued + ONE;
                    end
                    if (w_proc) begin
                        r_left <= r_left - ONE;
                    end
                    if (w_last) begin
                        if (w_drained) begin
                            r_state    <= S_DONE;
                            r_finish   <= 1'b1;
                            r_busy     <= 1'b0;
                            r_num_comp <= w_count;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_drained) begin
                        r_state    <= S_DONE;
                        r_finish   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_num_comp <= w_count;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oaram_valid    = w_hold.valid;
    assign oaram_data     = w_hold.output_data;
    assign oaram_indices  = w_hold.output_indices;
    assign busy           = r_busy;
    assign ppu_finish_en  = r_finish;
    assign num_compressed = r_num_comp;

endmodule
